corelet_seq: RTL and testbench
==============================

CORELET_SEQ -- requirements
Module: corelet_seq

Interface
REQ-001 SHALL have parameter ROW, default 8: PE rows, which is also the weight rows loaded per kernel position.
REQ-002 SHALL have parameter COL, default 8: PE columns, used for pipeline settle length.
REQ-003 SHALL have parameter KIJ, default 9: kernel positions per pass, minimum 1.
REQ-004 SHALL have parameter NPIX, default 16: output pixels streamed per kernel position, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-007 SHALL have port start, input, 1 bit: pass request, sampled in IDLE only.
REQ-008 SHALL have port mode, input, 1 bit: 0 = weight-stationary, 1 = output-stationary; latched on accepted start.
REQ-009 SHALL have port l0_wr_req, input, 1 bit: host request to write L0.
REQ-010 SHALL have port l0_ready, input, 1 bit: L0 holds at least one row.
REQ-011 SHALL have port l0_full, input, 1 bit: L0 full.
REQ-012 SHALL have port ofifo_valid, input, 1 bit: OFIFO holds at least one full psum vector.
REQ-013 SHALL have port ofifo_full, input, 1 bit: OFIFO full.
REQ-014 SHALL have port inst, output, 35 bits: corelet instruction word. Fields: [1:0] MAC op (00 idle, 01 load, 10 execute), [2] l0_wr, [3] l0_rd, [6] ofifo_rd, [33] sfp_acc, [34] mode_select. All other bits are 0.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at pass end.
REQ-017 SHALL have port kij_idx, output, $clog2(KIJ)+1 bits: current kernel position.
REQ-018 SHALL have port err, output, 1 bit: sticky overflow flag.

Function
REQ-019 SHALL implement an FSM with states IDLE, LOAD, SETTLE, EXEC, DRAIN and DONE; state and counters are registered, and inst is a combinational decode of state, counters and inputs.
REQ-020 SHALL, in IDLE with start=1, latch mode, clear kij_idx and the counter, and go to LOAD if mode=0 or EXEC if mode=1; start in any other state SHALL be ignored.
REQ-021 SHALL, in LOAD, drive inst[1:0]=01 and inst[3]=l0_ready, count only cycles with l0_ready=1, and go to SETTLE after ROW counted cycles.
REQ-022 SHALL, in SETTLE, drive inst[1:0]=00 for exactly ROW+COL-1 cycles, then go to EXEC.
REQ-023 SHALL, in EXEC, drive inst[1:0]=10 and inst[3] only while l0_ready=1 (when l0_ready=0, inst[1:0]=00 and the counter holds), and go to DRAIN after NPIX counted cycles.
REQ-024 SHALL, in DRAIN, drive inst[6]=ofifo_valid and inst[33]=ofifo_valid, count accepted reads, and after NPIX reads either increment kij_idx and return to LOAD (mode=0) or EXEC (mode=1), or go to DONE if kij_idx=KIJ-1.
REQ-025 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE.
REQ-026 SHALL drive inst[34] equal to the latched mode while busy=1, and 0 in IDLE.
REQ-027 SHALL drive inst[2] = l0_wr_req AND NOT l0_full in every state; a write is never issued into a full L0.
REQ-028 SHALL set err when ofifo_full=1 in EXEC while inst[1:0]=10; err SHALL stay set until reset, and the FSM SHALL continue unaffected.
REQ-029 SHALL handle KIJ=1 so that the first DRAIN completion goes directly to DONE.

Reset
REQ-030 SHALL, while reset=0, asynchronously force IDLE, zero all counters, kij_idx, latched mode and err, and drive inst=0, busy=0 and done=0, including when reset is asserted mid-pass; the FSM SHALL leave IDLE only on a start after reset deasserts.

Configuration
REQ-031 SHALL, with macro CORELET_SEQ_PERF_EN defined, add output stall_cnt (16 bits) that counts cycles in LOAD or EXEC with l0_ready=0, saturates at 16'hFFFF, is cleared on an accepted start and on reset, and holds its value in IDLE.
REQ-032 SHALL, without CORELET_SEQ_PERF_EN defined, have no stall_cnt port and no associated logic.

Verification
REQ-033 Bench SHALL cover: ROW=COL=8, KIJ=2, NPIX=4, mode=0, l0_ready and ofifo_valid held high -> per k: 8 LOAD + 15 SETTLE + 4 EXEC + 4 DRAIN cycles; done at cycle 63 after start; kij_idx sequence 0,1.
REQ-034 Bench SHALL cover: mode=1, KIJ=3, NPIX=4 -> no LOAD or SETTLE cycles; inst[34]=1 throughout; exactly 12 inst[33] pulses; one done pulse.
REQ-035 Bench SHALL cover: l0_ready=0 for 5 cycles mid-EXEC -> inst[1:0]=00 during the gap; EXEC lengthened by 5 cycles; stall_cnt=5 when CORELET_SEQ_PERF_EN is defined.
REQ-036 Bench SHALL cover: l0_full=1 with l0_wr_req=1 -> inst[2]=0; l0_full=0 -> inst[2]=1 in the same cycle.
REQ-037 Bench SHALL cover: ofifo_full=1 during EXEC -> err=1 and stays 1 through DONE; a start pulse during busy is ignored.
REQ-038 Bench SHALL cover: reset=0 asserted in DRAIN with kij_idx=1 -> inst=0, busy=0, kij_idx=0 and err=0 immediately; a new start runs a full pass.

Source files
------------

// File: rtl/corelet_seq.sv
// corelet_seq: pass sequencer for the corelet. It walks each kernel position
// through weight load, array settle, execute and drain, and decodes the
// 35-bit corelet instruction word from state, counters and handshake inputs.
// Ports:
//   clk, reset (async, active-low)
//   start, mode
//   l0_wr_req, l0_ready, l0_full
//   ofifo_valid, ofifo_full
//   inst[34:0], busy, done, kij_idx, err
//   stall_cnt[15:0] (only with CORELET_SEQ_PERF_EN)
// Build option: define CORELET_SEQ_PERF_EN to add the stall_cnt counter.
module corelet_seq #(
   parameter int ROW  = 8,
   parameter int COL  = 8,
   parameter int KIJ  = 9,
   parameter int NPIX = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 mode,
   input  logic                 l0_wr_req,
   input  logic                 l0_ready,
   input  logic                 l0_full,
   input  logic                 ofifo_valid,
   input  logic                 ofifo_full,
   output logic [34:0]          inst,
   output logic                 busy,
   output logic                 done,
   output logic [$clog2(KIJ):0] kij_idx,
   output logic                 err
`ifdef CORELET_SEQ_PERF_EN
   ,
   output logic [15:0]          stall_cnt
`endif
);

   localparam int KW = $clog2(KIJ) + 1;
   localparam int CW = $clog2(ROW + COL + NPIX) + 1;

   localparam logic [CW-1:0] ROW_LAST = CW'(ROW - 1);
   localparam logic [CW-1:0] SET_LAST = CW'(ROW + COL - 2);
   localparam logic [CW-1:0] PIX_LAST = CW'(NPIX - 1);
   localparam logic [KW-1:0] KIJ_LAST = KW'(KIJ - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_EXEC,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [KW-1:0] kij_q, kij_d;
   logic          mode_q, mode_d;
   logic          err_q, err_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         kij_q   <= '0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kij_q   <= kij_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      kij_d   = kij_q;
      mode_d  = mode_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = mode;
               kij_d   = '0;
               cnt_d   = '0;
               state_d = mode ? S_EXEC : S_LOAD;
            end
         end
         S_LOAD: begin
            // only cycles that actually move a row count toward ROW
            if (l0_ready) begin
               if (cnt_q == ROW_LAST) begin
                  cnt_d   = '0;
                  state_d = S_SETTLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_SETTLE: begin
            if (cnt_q == SET_LAST) begin
               cnt_d   = '0;
               state_d = S_EXEC;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_EXEC: begin
            if (l0_ready) begin
               // psums pushed into a full OFIFO are lost; flag, keep going
               if (ofifo_full) err_d = 1'b1;
               if (cnt_q == PIX_LAST) begin
                  cnt_d   = '0;
                  state_d = S_DRAIN;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_DRAIN: begin
            if (ofifo_valid) begin
               if (cnt_q == PIX_LAST) begin
                  cnt_d = '0;
                  if (kij_q == KIJ_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     kij_d   = kij_q + KW'(1);
                     state_d = mode_q ? S_EXEC : S_LOAD;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      inst = '0;
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
      // gated by reset so inst reads all-zero while reset is held
      inst[2]  = reset & l0_wr_req & ~l0_full;
      inst[34] = busy & mode_q;
      unique case (state_q)
         S_LOAD: begin
            inst[1:0] = 2'b01;
            inst[3]   = l0_ready;
         end
         S_EXEC: begin
            if (l0_ready) begin
               inst[1:0] = 2'b10;
               inst[3]   = 1'b1;
            end
         end
         S_DRAIN: begin
            inst[6]  = ofifo_valid;
            inst[33] = ofifo_valid;
         end
         default: ;
      endcase
   end

   assign kij_idx = kij_q;
   assign err     = err_q;

`ifdef CORELET_SEQ_PERF_EN
   logic [15:0] stall_q, stall_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   always_comb begin
      stall_d = stall_q;
      if (state_q == S_IDLE && start) begin
         stall_d = '0;
      end else if ((state_q == S_LOAD || state_q == S_EXEC) &&
                   !l0_ready && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_corelet_seq.sv
// tb_corelet_seq: drives three corelet_seq instances (KIJ = 1, 2, 3) with a
// shared stimulus and compares each one against a pass-schedule model.
module tb_corelet_seq;

   localparam int ROW  = 8;
   localparam int COL  = 8;
   localparam int NPIX = 4;
   localparam int NMAX = 600;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, start, mode, l0_wr_req, l0_ready;
   logic l0_full, ofifo_valid, ofifo_full;

   logic [34:0] o_inst [3];
   logic        o_busy [3];
   logic        o_done [3];
   logic        o_err  [3];
   logic [0:0]  k1;
   logic [1:0]  k2;
   logic [2:0]  k3;
   logic [2:0]  o_kij  [3];
`ifdef CORELET_SEQ_PERF_EN
   logic [15:0] o_stall [3];
`endif

   assign o_kij[0] = {2'b00, k1};
   assign o_kij[1] = {1'b0, k2};
   assign o_kij[2] = k3;

   corelet_seq #(.ROW(ROW), .COL(COL), .KIJ(1), .NPIX(NPIX)) u1 (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .l0_wr_req(l0_wr_req), .l0_ready(l0_ready), .l0_full(l0_full),
      .ofifo_valid(ofifo_valid), .ofifo_full(ofifo_full),
      .inst(o_inst[0]), .busy(o_busy[0]), .done(o_done[0]),
      .kij_idx(k1), .err(o_err[0])
`ifdef CORELET_SEQ_PERF_EN
      , .stall_cnt(o_stall[0])
`endif
   );

   corelet_seq #(.ROW(ROW), .COL(COL), .KIJ(2), .NPIX(NPIX)) u2 (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .l0_wr_req(l0_wr_req), .l0_ready(l0_ready), .l0_full(l0_full),
      .ofifo_valid(ofifo_valid), .ofifo_full(ofifo_full),
      .inst(o_inst[1]), .busy(o_busy[1]), .done(o_done[1]),
      .kij_idx(k2), .err(o_err[1])
`ifdef CORELET_SEQ_PERF_EN
      , .stall_cnt(o_stall[1])
`endif
   );

   corelet_seq #(.ROW(ROW), .COL(COL), .KIJ(3), .NPIX(NPIX)) u3 (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .l0_wr_req(l0_wr_req), .l0_ready(l0_ready), .l0_full(l0_full),
      .ofifo_valid(ofifo_valid), .ofifo_full(ofifo_full),
      .inst(o_inst[2]), .busy(o_busy[2]), .done(o_done[2]),
      .kij_idx(k3), .err(o_err[2])
`ifdef CORELET_SEQ_PERF_EN
      , .stall_cnt(o_stall[2])
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   bit s_st [NMAX], s_md [NMAX], s_lr [NMAX], s_ov [NMAX];
   bit s_of [NMAX], s_wr [NMAX], s_lf [NMAX];

   logic [34:0] e_inst  [3][NMAX];
   bit          e_busy  [3][NMAX];
   bit          e_done  [3][NMAX];
   bit          e_err   [3][NMAX];
   int          e_kij   [3][NMAX];
   int          e_stall [3][NMAX];

   logic [34:0] ob_inst [3][NMAX];
   bit          ob_done [3][NMAX];
   bit          ob_busy [3][NMAX];
   int          ob_kij  [3][NMAX];

   bit m_err  [3];
   bit m_mode [3];
   int m_kij  [3];
   int m_stall[3];

   task automatic chk(input string nm, input int i, input int t,
                      input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s u%0d t=%0d obs=%0h exp=%0h", nm, i + 1, t, obs, exp);
      end
   endtask

   // model output for one cycle, from register values before the edge
   task automatic emit(input int i, input int t, input bit bsy, input bit dn,
                       input bit [1:0] op, input bit rd, input bit rdo);
      logic [34:0] v;
      v      = '0;
      v[1:0] = op;
      v[2]   = s_wr[t] & ~s_lf[t];
      v[3]   = rd;
      v[6]   = rdo;
      v[33]  = rdo;
      v[34]  = bsy & m_mode[i];
      e_inst[i][t]  = v;
      e_busy[i][t]  = bsy;
      e_done[i][t]  = dn;
      e_kij[i][t]   = m_kij[i];
      e_err[i][t]   = m_err[i];
      e_stall[i][t] = m_stall[i];
   endtask

   task automatic stall_inc(input int i);
      if (m_stall[i] < 65535) m_stall[i]++;
   endtask

   // schedule of a whole stimulus window; instance i has KIJ = i+1
   task automatic build(input int i, input int n);
      int t;
      int cnt;
      t = 0;
      while (t < n) begin
         emit(i, t, 0, 0, 2'b00, 0, 0);
         if (!s_st[t]) begin
            t++;
         end else begin
            m_mode[i]  = s_md[t];
            m_kij[i]   = 0;
            m_stall[i] = 0;
            t++;
            for (int k = 0; k < i + 1 && t < n; k++) begin
               if (!m_mode[i]) begin
                  cnt = 0;
                  while (cnt < ROW && t < n) begin
                     emit(i, t, 1, 0, 2'b01, s_lr[t], 0);
                     if (s_lr[t]) cnt++;
                     else stall_inc(i);
                     t++;
                  end
                  for (int j = 0; j < ROW + COL - 1 && t < n; j++) begin
                     emit(i, t, 1, 0, 2'b00, 0, 0);
                     t++;
                  end
               end
               cnt = 0;
               while (cnt < NPIX && t < n) begin
                  if (s_lr[t]) begin
                     emit(i, t, 1, 0, 2'b10, 1, 0);
                     if (s_of[t]) m_err[i] = 1'b1;
                     cnt++;
                  end else begin
                     emit(i, t, 1, 0, 2'b00, 0, 0);
                     stall_inc(i);
                  end
                  t++;
               end
               cnt = 0;
               while (cnt < NPIX && t < n) begin
                  emit(i, t, 1, 0, 2'b00, 0, s_ov[t]);
                  if (s_ov[t]) cnt++;
                  t++;
               end
               if (k < i) m_kij[i]++;
            end
            if (t < n) begin
               emit(i, t, 1, 1, 2'b00, 0, 0);
               t++;
            end
         end
      end
   endtask

   task automatic clear_stim(input int n);
      for (int t = 0; t < n; t++) begin
         s_st[t] = 0; s_md[t] = 0; s_lr[t] = 1; s_ov[t] = 1; s_of[t] = 0;
         s_wr[t] = 1'($urandom);
         s_lf[t] = 1'($urandom);
      end
   endtask

   // entered and left at posedge+1
   task automatic run_seq(input int n);
      for (int i = 0; i < 3; i++) build(i, n);
      for (int t = 0; t < n; t++) begin
         start = s_st[t]; mode = s_md[t]; l0_ready = s_lr[t];
         ofifo_valid = s_ov[t]; ofifo_full = s_of[t];
         l0_wr_req = s_wr[t]; l0_full = s_lf[t];
         #2;
         for (int i = 0; i < 3; i++) begin
            ob_inst[i][t] = o_inst[i];
            ob_done[i][t] = o_done[i];
            ob_busy[i][t] = o_busy[i];
            ob_kij[i][t]  = int'(o_kij[i]);
            chk("inst", i, t, 64'(o_inst[i]), 64'(e_inst[i][t]));
            chk("busy", i, t, 64'(o_busy[i]), 64'(e_busy[i][t]));
            chk("done", i, t, 64'(o_done[i]), 64'(e_done[i][t]));
            chk("kij",  i, t, 64'(o_kij[i]),  64'(e_kij[i][t]));
            chk("err",  i, t, 64'(o_err[i]),  64'(e_err[i][t]));
`ifdef CORELET_SEQ_PERF_EN
            chk("stall", i, t, 64'(o_stall[i]), 64'(e_stall[i][t]));
`endif
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   function automatic int first_done(input int i, input int n);
      for (int t = 0; t < n; t++) if (ob_done[i][t]) return t;
      return -1;
   endfunction

   function automatic int cnt_done(input int i, input int n);
      int c = 0;
      for (int t = 0; t < n; t++) if (ob_done[i][t]) c++;
      return c;
   endfunction

   function automatic int cnt_busy(input int i, input int n);
      int c = 0;
      for (int t = 0; t < n; t++) if (ob_busy[i][t]) c++;
      return c;
   endfunction

   function automatic int cnt_bit(input int i, input int n, input int b);
      int c = 0;
      for (int t = 0; t < n; t++) if (ob_inst[i][t][b]) c++;
      return c;
   endfunction

   function automatic int first_bit(input int i, input int n, input int b);
      for (int t = 0; t < n; t++) if (ob_inst[i][t][b]) return t;
      return -1;
   endfunction

   function automatic int cnt_op(input int i, input int n, input logic [1:0] op);
      int c = 0;
      for (int t = 0; t < n; t++) if (ob_inst[i][t][1:0] == op) c++;
      return c;
   endfunction

   function automatic int mode_viol(input int i, input int n);
      int c = 0;
      for (int t = 0; t < n; t++)
         if (ob_busy[i][t] && !ob_inst[i][t][34]) c++;
      return c;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int pass_len;
      pass_len = 2 * ROW + COL - 1 + 2 * NPIX;
      for (int i = 0; i < 3; i++) begin
         m_err[i] = 0; m_mode[i] = 0; m_kij[i] = 0; m_stall[i] = 0;
      end

      // reset state, with a write request that would otherwise show
      reset = 1'b0; start = 1'b1; mode = 1'b1; l0_wr_req = 1'b1;
      l0_ready = 1'b1; l0_full = 1'b0; ofifo_valid = 1'b1; ofifo_full = 1'b1;
      #12;
      for (int i = 0; i < 3; i++) begin
         chk("rst_inst", i, -1, 64'(o_inst[i]), 64'd0);
         chk("rst_busy", i, -1, 64'(o_busy[i]), 64'd0);
         chk("rst_done", i, -1, 64'(o_done[i]), 64'd0);
         chk("rst_kij",  i, -1, 64'(o_kij[i]),  64'd0);
         chk("rst_err",  i, -1, 64'(o_err[i]),  64'd0);
      end
      @(posedge clk); #2;
      chk("rst_hold_busy", 2, -1, 64'(o_busy[2]), 64'd0);
      start = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;

      // weight-stationary pass, inputs always ready
      clear_stim(120);
      s_st[0] = 1;
      run_seq(120);
      for (int i = 0; i < 3; i++) begin
         chk("ws_done_at", i, -1, 64'(first_done(i, 120)),
             64'(1 + (i + 1) * pass_len));
         chk("ws_ndone", i, -1, 64'(cnt_done(i, 120)), 64'd1);
         chk("ws_idle_end", i, -1, 64'(ob_busy[i][119]), 64'd0);
      end
      chk("ws_load_cyc", 1, -1, 64'(cnt_op(1, 120, 2'b01)), 64'(2 * ROW));
      chk("ws_exec_cyc", 1, -1, 64'(cnt_op(1, 120, 2'b10)), 64'(2 * NPIX));
      chk("ws_kij0", 1, 1, 64'(ob_kij[1][1]), 64'd0);
      chk("ws_kij1", 1, 1 + pass_len, 64'(ob_kij[1][1 + pass_len]), 64'd1);

      // output-stationary pass
      clear_stim(60);
      s_st[0] = 1; s_md[0] = 1;
      run_seq(60);
      chk("os_sfp",   2, -1, 64'(cnt_bit(2, 60, 33)), 64'(3 * NPIX));
      chk("os_ndone", 2, -1, 64'(cnt_done(2, 60)), 64'd1);
      chk("os_busy",  2, -1, 64'(cnt_busy(2, 60)), 64'(3 * 2 * NPIX + 1));
      chk("os_load",  2, -1, 64'(cnt_op(2, 60, 2'b01)), 64'd0);
      chk("os_mode",  2, -1, 64'(mode_viol(2, 60)), 64'd0);

      // five-cycle l0_ready gap inside the first EXEC
      clear_stim(60);
      s_st[0] = 1; s_md[0] = 1;
      for (int t = 3; t < 8; t++) s_lr[t] = 0;
      run_seq(60);
      chk("gap_op",    2, 5, 64'(ob_inst[2][5][1:0]), 64'd0);
      chk("gap_drain", 2, -1, 64'(first_bit(2, 60, 6)), 64'(1 + NPIX + 5));
      chk("gap_busy",  2, -1, 64'(cnt_busy(2, 60)), 64'(3 * 2 * NPIX + 1 + 5));
`ifdef CORELET_SEQ_PERF_EN
      chk("gap_stall", 2, -1, 64'(o_stall[2]), 64'd5);
`endif

      // L0 write gating, same-cycle response
      l0_wr_req = 1'b1; l0_full = 1'b1;
      #1;
      for (int i = 0; i < 3; i++)
         chk("wr_full", i, -1, 64'(o_inst[i][2]), 64'd0);
      l0_full = 1'b0;
      #1;
      for (int i = 0; i < 3; i++)
         chk("wr_free", i, -1, 64'(o_inst[i][2]), 64'd1);
      @(posedge clk); #1;

      // OFIFO overflow during EXEC, extra start pulses while busy
      clear_stim(120);
      s_st[0] = 1; s_st[10] = 1; s_st[40] = 1;
      for (int t = 0; t < 120; t++) s_of[t] = 1;
      run_seq(120);
      chk("ovf_done_at", 2, -1, 64'(first_done(2, 120)), 64'(1 + 3 * pass_len));
      chk("ovf_ndone3",  2, -1, 64'(cnt_done(2, 120)), 64'd1);
      chk("ovf_ndone2",  1, -1, 64'(cnt_done(1, 120)), 64'd1);
      chk("ovf_ndone1",  0, -1, 64'(cnt_done(0, 120)), 64'd2);
      for (int i = 0; i < 3; i++)
         chk("ovf_err", i, -1, 64'(o_err[i]), 64'd1);

      // randomized traffic, then a settled tail
      clear_stim(520);
      for (int t = 0; t < 380; t++) begin
         s_st[t] = ($urandom_range(0, 19) == 0);
         s_md[t] = 1'($urandom);
         s_lr[t] = ($urandom_range(0, 3) != 0);
         s_ov[t] = ($urandom_range(0, 3) != 0);
         s_of[t] = ($urandom_range(0, 7) == 0);
      end
      run_seq(520);
      for (int i = 0; i < 3; i++)
         chk("rnd_idle_end", i, -1, 64'(o_busy[i]), 64'd0);

      // reset asserted in the second DRAIN of the KIJ=2 instance
      clear_stim(59);
      for (int t = 0; t < 59; t++) begin
         s_wr[t] = 1; s_lf[t] = 0;
      end
      s_st[0] = 1;
      run_seq(59);
      start = 1'b0; l0_ready = 1'b1; ofifo_valid = 1'b1;
      ofifo_full = 1'b0; l0_wr_req = 1'b1; l0_full = 1'b0;
      #2;
      chk("pre_rst_kij",   1, 59, 64'(o_kij[1]), 64'd1);
      chk("pre_rst_drain", 1, 59, 64'(o_inst[1][6]), 64'd1);
      reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("mid_rst_inst", i, -1, 64'(o_inst[i]), 64'd0);
         chk("mid_rst_busy", i, -1, 64'(o_busy[i]), 64'd0);
         chk("mid_rst_kij",  i, -1, 64'(o_kij[i]),  64'd0);
         chk("mid_rst_err",  i, -1, 64'(o_err[i]),  64'd0);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         m_err[i] = 0; m_mode[i] = 0; m_kij[i] = 0; m_stall[i] = 0;
      end
      @(posedge clk); #1;
      chk("post_rst_idle", 1, -1, 64'(o_busy[1]), 64'd0);
      clear_stim(120);
      s_st[0] = 1;
      run_seq(120);
      chk("rerun_done_at", 1, -1, 64'(first_done(1, 120)), 64'(1 + 2 * pass_len));
      chk("rerun_ndone",   2, -1, 64'(cnt_done(2, 120)), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
